// File: rtl/div_seq32_pkg.sv
// Shared constants for the sequential 32-bit divider: operand width,
// iteration counter sizing and the controller state encoding.
package div_seq32_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int SUB_W     = DIV_WIDTH + 1;
   localparam int CNT_W     = 5;

   // One restoring step per quotient bit; the counter counts down to zero.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

   // Magnitude of a two's-complement operand when signed mode is selected,
   // raw value otherwise. 0x80000000 maps onto itself, which the unsigned
   // core treats as 2^31 - exactly what the overflow case needs.
   function automatic logic [DIV_WIDTH-1:0] abs_if(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 en);
      abs_if = (en && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_seq32_sub33.sv
// 33-bit subtractor for the restoring step: a ripple chain of full-adder
// cells computing a + ~b + 1. borrow is high when b > a.
module div_seq32_sub33
   import div_seq32_pkg::*;
(
   input  logic [SUB_W-1:0] a,
   input  logic [SUB_W-1:0] b,
   output logic [SUB_W-1:0] diff,
   output logic             borrow
);

   logic [SUB_W:0]   carry;
   logic [SUB_W-1:0] b_inv;

   assign b_inv    = ~b;
   assign carry[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < SUB_W; gi++) begin : g_fa
         assign diff[gi]      = a[gi] ^ b_inv[gi] ^ carry[gi];
         assign carry[gi + 1] = (a[gi] & b_inv[gi]) | (carry[gi] & (a[gi] ^ b_inv[gi]));
      end
   endgenerate

   // No carry out of the top cell means the subtraction wrapped.
   assign borrow = ~carry[SUB_W];

endmodule

// File: rtl/div_seq32.sv
// Sequential restoring divider, one quotient bit per clock. Signed operands
// are divided as magnitudes and the signs are restored in a single fix-up
// cycle. Results are published only when done pulses and are held until the
// next accepted request.
module div_seq32
   import div_seq32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_work_q, quo_work_d;   // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] rem_work_q, rem_work_d;   // partial remainder
   logic [WIDTH-1:0] dvs_q, dvs_d;             // divisor magnitude
   logic             signed_q, signed_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             dbz_work_q, dbz_work_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [SUB_W-1:0] shifted_rem;
   logic [SUB_W-1:0] trial;
   logic             trial_borrow;
   logic             step_ok;

   // The partial remainder is always below the divisor, so after the shift
   // it fits in 33 bits; the trial subtraction is done at that width.
   assign shifted_rem = {rem_work_q, quo_work_q[WIDTH-1]};

   div_seq32_sub33 u_sub33 (
      .a      (shifted_rem),
      .b      ({1'b0, dvs_q}),
      .diff   (trial),
      .borrow (trial_borrow)
   );

   // A committed difference is below the divisor, so its top bit is clear;
   // requiring it keeps the commit test a full 33-bit non-negative check.
   assign step_ok = ~trial_borrow & ~trial[SUB_W-1];

   // Next-state and datapath updates for the divide controller.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quo_work_d = quo_work_q;
      rem_work_d = rem_work_q;
      dvs_d      = dvs_q;
      signed_d   = signed_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      dbz_work_d = dbz_work_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dbz_d      = dbz_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               signed_d = is_signed;
               sign_a_d = is_signed & dividend[WIDTH-1];
               sign_b_d = is_signed & divisor[WIDTH-1];
               cnt_d    = CNT_LOAD;
               if (divisor == '0) begin
                  // Divide by zero skips the iterations entirely.
                  quo_work_d = '1;
                  rem_work_d = dividend;
                  dvs_d      = '0;
                  dbz_work_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  quo_work_d = abs_if(dividend, is_signed);
                  rem_work_d = '0;
                  dvs_d      = abs_if(divisor, is_signed);
                  dbz_work_d = 1'b0;
                  state_d    = S_RUN;
               end
            end
         end

         S_RUN: begin
            if (step_ok) begin
               rem_work_d = trial[WIDTH-1:0];
               quo_work_d = {quo_work_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_work_d = shifted_rem[WIDTH-1:0];
               quo_work_d = {quo_work_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_FIX: begin
            // Quotient takes the sign of the product of signs, the remainder
            // takes the sign of the dividend (truncating division).
            if (signed_q && (sign_a_q ^ sign_b_q)) begin
               quo_work_d = ~quo_work_q + 1'b1;
            end
            if (signed_q && sign_a_q) begin
               rem_work_d = ~rem_work_q + 1'b1;
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            quot_d  = quo_work_q;
            rem_d   = rem_work_q;
            dbz_d   = dbz_work_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         quo_work_q <= '0;
         rem_work_q <= '0;
         dvs_q      <= '0;
         signed_q   <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         dbz_work_q <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         quo_work_q <= quo_work_d;
         rem_work_q <= rem_work_d;
         dvs_q      <= dvs_d;
         signed_q   <= signed_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         dbz_work_q <= dbz_work_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dbz_q      <= dbz_d;
         done_q     <= done_d;
      end
   end

   // The done cycle is spent back in IDLE, so busy is already low there.
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/div_seq32.md
DIV_SEQ32 -- requirements
Module: div_seq32

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  1 selects two's-complement division, 0 selects unsigned; sampled with start.
REQ-006 Port: dividend  input  32  numerator; sampled with start.
REQ-007 Port: divisor  input  32  denominator; sampled with start.
REQ-008 Port: busy  output  1  high from the cycle after start is accepted until done.
REQ-009 Port: done  output  1  one-cycle pulse when results become valid.
REQ-010 Port: quotient  output  32  result quotient; held until the next accepted start.
REQ-011 Port: remainder  output  32  result remainder; held until the next accepted start.
REQ-012 Port: div_by_zero  output  1  set with done when divisor==0; held until the next accepted start.

Function
REQ-013 FSM states SHALL be: IDLE, RUN, FIX, DONE.
REQ-014 IDLE->RUN on start=1: latch |dividend|, |divisor| (absolute values when is_signed=1, raw values otherwise), latch both sign bits, clear the partial remainder, load iteration counter=31.
REQ-015 IDLE->DONE on start=1 with divisor==0: quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1, no RUN cycles.
REQ-016 RUN performs one restoring step per cycle:
- shift {partial_rem, dividend_reg} left by one;
- compute trial=partial_rem-divisor in 33 bits;
- if trial is non-negative, commit trial and shift in quotient bit 1, else keep partial_rem and shift in 0.
REQ-017 RUN->FIX when the counter reaches 0 (exactly 32 RUN cycles); the counter decrements with no wrap.
REQ-018 FIX: if is_signed and the sign bits differ, negate the quotient; if is_signed and the dividend was negative, negate the remainder; then ->DONE.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield quotient=0x80000000 and remainder=0 through the normal datapath, with no special case.
REQ-020 DONE: done=1 for exactly one cycle, busy=0, then ->IDLE.
REQ-021 Latency: start accepted at edge N; done is high in the cycle following edge N+34 (normal) or edge N+1 (divide-by-zero).
REQ-022 start asserted while busy=1 or in DONE SHALL be ignored, with no effect on the operation in flight.
REQ-023 Back-to-back: start may be asserted in the cycle after done and SHALL be accepted.
REQ-024 quotient, remainder and div_by_zero SHALL NOT change while busy=1; they update only in the cycle done asserts.

Reset
REQ-025 On rst=1 at a clock edge, state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and counter and working registers are cleared.
REQ-026 rst mid-operation SHALL abort without a done pulse; rst takes priority over a simultaneous start.

Structure
REQ-027 The FSM state encoding and WIDTH SHALL be defined in the shared processor constants package/header, not locally.
REQ-028 A single sub-module sub33 (33-bit subtractor built from the existing adder cells, with the divisor inverted and c_in=1) SHALL produce the trial difference and borrow.
REQ-029 The block SHALL use no combinational divider and no multi-step-per-cycle unrolling.

Verification
REQ-030 Unsigned 100/7 -> quotient=14, remainder=2, done exactly 34 cycles after start accepted, busy high for 34 cycles.
REQ-031 Signed 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-032 0x1234/0 (either mode) -> quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, done 1 cycle after acceptance.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-034 start pulsed at RUN cycle 5 with different operands -> ignored, first result unchanged; rst at RUN cycle 10 -> no done, all outputs 0, next start (9/3) -> quotient=3, remainder=0.
